// File: rtl/pwr_switch_ack_emu_pkg.sv
// Shared types and helpers for the power-switch acknowledge emulator.
// Latency arithmetic is done at 32 bits; LAT_W is expected to be at most 32.
package pwr_switch_ack_emu_pkg;

  typedef enum logic [1:0] {OFF, RAMP_ON, ON, RAMP_OFF} sw_state_e;

  localparam int LAT_W_DEFAULT = 8;

  // A programmed latency of zero behaves like a single-cycle switch.
  function automatic logic [31:0] eff_lat(input logic [31:0] lat);
    return (lat == 32'd0) ? 32'd1 : lat;
  endfunction

endpackage

// File: rtl/pwr_switch_ack_emu_ch.sv
// One power domain: request-to-acknowledge FSM with a loadable ramp counter.
// The latency inputs are already clamped to a minimum of 1.
module pwr_switch_ack_emu_ch
  import pwr_switch_ack_emu_pkg::*;
#(
  parameter int   LAT_W   = LAT_W_DEFAULT,
  parameter logic INIT_ON = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             switch_i,
  input  logic [LAT_W-1:0] on_lat_i,
  input  logic [LAT_W-1:0] off_lat_i,
  output logic             ack_o,
  output logic             done_o,
  output logic             busy_o
);

  sw_state_e        state_reg, state_next;
  logic [LAT_W-1:0] cnt_reg, cnt_next;
  logic             ack_reg, ack_next;
  logic             done_reg, done_next;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= INIT_ON ? ON : OFF;
      cnt_reg   <= '0;
      ack_reg   <= INIT_ON;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ack_reg   <= ack_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ack_next   = ack_reg;
    done_next  = 1'b0;
    unique case (state_reg)
      OFF: begin
        if (switch_i) begin
          if (on_lat_i == LAT_W'(1)) begin
            state_next = ON;
            ack_next   = 1'b1;
            done_next  = 1'b1;
          end else begin
            state_next = RAMP_ON;
            cnt_next   = on_lat_i - LAT_W'(1);
          end
        end
      end
      RAMP_ON: begin
        // Request dropped before the ramp completed: a glitch, discard it.
        if (!switch_i) begin
          state_next = OFF;
          cnt_next   = '0;
        end else if (cnt_reg == LAT_W'(1)) begin
          state_next = ON;
          cnt_next   = '0;
          ack_next   = 1'b1;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg - LAT_W'(1);
        end
      end
      ON: begin
        if (!switch_i) begin
          if (off_lat_i == LAT_W'(1)) begin
            state_next = OFF;
            ack_next   = 1'b0;
            done_next  = 1'b1;
          end else begin
            state_next = RAMP_OFF;
            cnt_next   = off_lat_i - LAT_W'(1);
          end
        end
      end
      RAMP_OFF: begin
        if (switch_i) begin
          state_next = ON;
          cnt_next   = '0;
        end else if (cnt_reg == LAT_W'(1)) begin
          state_next = OFF;
          cnt_next   = '0;
          ack_next   = 1'b0;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg - LAT_W'(1);
        end
      end
      default: state_next = OFF;
    endcase
  end

  assign ack_o  = ack_reg;
  assign done_o = done_reg;
  assign busy_o = (state_reg == RAMP_ON) || (state_reg == RAMP_OFF);

endmodule

// File: rtl/pwr_switch_ack_emu.sv
// Multi-domain power-switch acknowledge emulator with runtime-writable
// on/off latencies shared by all channels.
module pwr_switch_ack_emu
  import pwr_switch_ack_emu_pkg::*;
#(
  parameter int             NCH         = 4,
  parameter int             LAT_W       = LAT_W_DEFAULT,
  parameter int             ON_LATENCY  = 15,
  parameter int             OFF_LATENCY = 15,
  parameter logic [NCH-1:0] INIT_ON     = '1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NCH-1:0]   switch_i,
  output logic [NCH-1:0]   ack_o,
  output logic [NCH-1:0]   done_o,
  output logic             busy_o,
  input  logic             cfg_we_i,
  input  logic [LAT_W-1:0] cfg_on_lat_i,
  input  logic [LAT_W-1:0] cfg_off_lat_i
);

  logic [LAT_W-1:0] on_lat_reg;
  logic [LAT_W-1:0] off_lat_reg;
  logic [LAT_W-1:0] on_eff;
  logic [LAT_W-1:0] off_eff;
  logic [NCH-1:0]   busy_ch;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      on_lat_reg  <= LAT_W'(ON_LATENCY);
      off_lat_reg <= LAT_W'(OFF_LATENCY);
    end else if (cfg_we_i) begin
      on_lat_reg  <= cfg_on_lat_i;
      off_lat_reg <= cfg_off_lat_i;
    end
  end

  // Channels see the pre-write value on a write edge, so a ramp starting
  // on that edge keeps the old latency.
  assign on_eff  = LAT_W'(eff_lat(32'(on_lat_reg)));
  assign off_eff = LAT_W'(eff_lat(32'(off_lat_reg)));

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      pwr_switch_ack_emu_ch #(
        .LAT_W   (LAT_W),
        .INIT_ON (INIT_ON[gi])
      ) u_ch (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .switch_i  (switch_i[gi]),
        .on_lat_i  (on_eff),
        .off_lat_i (off_eff),
        .ack_o     (ack_o[gi]),
        .done_o    (done_o[gi]),
        .busy_o    (busy_ch[gi])
      );
    end
  endgenerate

  assign busy_o = |busy_ch;

endmodule

// File: tb/tb_pwr_switch_ack_emu.sv
// Scoreboard bench: stimulus queues expected ack/done events, a monitor
// checks each done pulse against the queue and flags any silent ack change.
module tb_pwr_switch_ack_emu;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [3:0] switch_i;
  logic [3:0] ack_o;
  logic [3:0] done_o;
  logic       busy_o;
  logic       cfg_we_i;
  logic [7:0] cfg_on_lat_i;
  logic [7:0] cfg_off_lat_i;

  typedef struct {
    int         cyc;
    logic [3:0] ack;
    logic [3:0] done;
  } ev_t;

  ev_t        exp_q[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         busy_cnt = 0;
  logic       rst_q = 1'b1;
  logic [3:0] ack_prev = 4'b0;

  always #5 clk = ~clk;

  pwr_switch_ack_emu #(
    .NCH         (4),
    .LAT_W       (8),
    .ON_LATENCY  (15),
    .OFF_LATENCY (15),
    .INIT_ON     (4'b0101)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .switch_i      (switch_i),
    .ack_o         (ack_o),
    .done_o        (done_o),
    .busy_o        (busy_o),
    .cfg_we_i      (cfg_we_i),
    .cfg_on_lat_i  (cfg_on_lat_i),
    .cfg_off_lat_i (cfg_off_lat_i)
  );

  always @(posedge clk) begin
    cyc   = cyc + 1;
    rst_q = rst_i;
  end

  // Monitor: every done pulse must match the head of the queue; ack must
  // never change without one (except across a reset edge).
  always @(negedge clk) begin
    if (!rst_q) begin
      if (busy_o) busy_cnt = busy_cnt + 1;
      if (done_o != 4'b0) begin
        tests = tests + 1;
        if (exp_q.size() == 0) begin
          fails = fails + 1;
          $display("FAIL unexpected_done cyc=%0d done=%b ack=%b", cyc, done_o, ack_o);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.ack != ack_o || e.done != done_o) begin
            fails = fails + 1;
            $display("FAIL event cyc=%0d/%0d ack=%b/%b done=%b/%b (actual/expected)",
                     cyc, e.cyc, ack_o, e.ack, done_o, e.done);
          end else begin
            $display("[TB] event ok cyc=%0d ack=%b done=%b", cyc, ack_o, done_o);
          end
        end
      end else if (ack_o != ack_prev) begin
        tests = tests + 1;
        fails = fails + 1;
        $display("FAIL silent_ack cyc=%0d ack=%b prev=%b", cyc, ack_o, ack_prev);
      end
    end
    ack_prev = ack_o;
  end

  task automatic check(input string name, input int act, input int exp);
    tests = tests + 1;
    if (act != exp) begin
      fails = fails + 1;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end else begin
      $display("[TB] %s ok value=%0d", name, act);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a new request pattern just after an edge; the expected ack change
  // lands lat edges later.
  task automatic start(input logic [3:0] sw, input logic [3:0] ack_e,
                       input logic [3:0] done_e, input int lat);
    ev_t e;
    @(posedge clk);
    #1;
    e.cyc  = cyc + lat;
    e.ack  = ack_e;
    e.done = done_e;
    exp_q.push_back(e);
    busy_cnt = 0;
    switch_i = sw;
  endtask

  task automatic write_cfg(input logic [7:0] on_l, input logic [7:0] off_l);
    @(posedge clk);
    #1;
    cfg_we_i = 1'b1;
    cfg_on_lat_i = on_l;
    cfg_off_lat_i = off_l;
    tick(1);
    cfg_we_i = 1'b0;
  endtask

  initial begin
    ev_t e;
    rst_i = 1'b1;
    switch_i = 4'b0101;
    cfg_we_i = 1'b0;
    cfg_on_lat_i = 8'd0;
    cfg_off_lat_i = 8'd0;
    tick(3);
    rst_i = 1'b0;
    tick(1);

    // Reset state
    check("reset_ack", int'(ack_o), 5);
    check("reset_done", int'(done_o), 0);
    check("reset_busy", int'(busy_o), 0);

    // Glitch on channel 1: 10 cycles high with L=15 never reaches ack
    @(posedge clk);
    #1;
    busy_cnt = 0;
    switch_i = 4'b0111;
    tick(10);
    switch_i = 4'b0101;
    tick(3);
    check("glitch_busy_cycles", busy_cnt, 10);
    check("glitch_busy_after", int'(busy_o), 0);
    check("glitch_ack", int'(ack_o), 5);

    // Default latency 15 on channel 1
    start(4'b0111, 4'b0111, 4'b0010, 15);
    tick(20);
    check("ramp15_busy_cycles", busy_cnt, 14);

    // Write on the same edge a ramp starts: that ramp keeps latency 15
    @(posedge clk);
    #1;
    e.cyc = cyc + 15;
    e.ack = 4'b1111;
    e.done = 4'b1000;
    exp_q.push_back(e);
    switch_i = 4'b1111;
    cfg_we_i = 1'b1;
    cfg_on_lat_i = 8'd3;
    cfg_off_lat_i = 8'd0;
    tick(1);
    cfg_we_i = 1'b0;
    tick(20);

    // Off latency 0 behaves as 1, on latency 3
    start(4'b0111, 4'b0111, 4'b1000, 1);
    tick(4);
    check("lat0_busy_cycles", busy_cnt, 0);
    start(4'b1111, 4'b1111, 4'b1000, 3);
    tick(6);
    check("lat3_busy_cycles", busy_cnt, 2);

    // All channels in parallel with L=5
    write_cfg(8'd5, 8'd5);
    start(4'b0000, 4'b0000, 4'b1111, 5);
    tick(8);
    start(4'b1111, 4'b1111, 4'b1111, 5);
    tick(8);

    // Reset in the middle of a RAMP_OFF on channel 0: ramp lost, no done
    @(posedge clk);
    #1;
    switch_i = 4'b1110;
    tick(2);
    check("mid_ramp_busy", int'(busy_o), 1);
    rst_i = 1'b1;
    switch_i = 4'b0101;
    tick(1);
    rst_i = 1'b0;
    tick(8);
    check("post_reset_ack", int'(ack_o), 5);
    check("post_reset_busy", int'(busy_o), 0);

    // Latency registers back at 15
    start(4'b0111, 4'b0111, 4'b0010, 15);
    tick(20);
    check("post_reset_lat15_busy", busy_cnt, 14);

    begin
      int guard = 0;
      while (exp_q.size() != 0 && guard < 100) begin
        tick(1);
        guard++;
      end
    end
    check("events_outstanding", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
